mem_stage_lsu: RTL

Parametrised RISC-V-lite memory stage with load/store unit. It sits between EX/MEM and MEM/WB. It resolves all six conditional branch types plus jumps into `PC_sel`, and drives a request/grant/rvalid data-memory port with byte enables. Loads are sign- or zero-extended. The stage stalls the upstream pipeline while a memory access is outstanding, and registers ALU result, NPC, immediate, load data and destination info into the MEM/WB register with a valid bit.

---
 rtl/mem_stage_lsu_if.sv | 26 ++
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/rvalid bus between the load/store unit and memory.
// The LSU is the master; the memory (or bench) is the slave.
interface mem_stage_lsu_if #(
  parameter int N = 32
);
  localparam int NB = N / 8;

  logic          dmem_req;
  logic          dmem_we;
  logic [N-1:0]  dmem_addr;
  logic [NB-1:0] dmem_be;
  logic [N-1:0]  dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [N-1:0]  dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: branch/jump resolution, data-memory access with byte enables,
// load extension and the MEM/WB register.
//
// state  | meaning
// S_IDLE | accepting a new EX/MEM instruction; memory ops request combinationally
// S_REQ  | request issued but not yet granted; fields held by the upstream stall
// S_WAIT | load granted, waiting for rvalid
module mem_stage_lsu #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic            branch_en,
  input  logic            jump_en,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            lt,
  input  logic            ltu,
  input  logic            mem_rd_en,
  input  logic            mem_wr_en,
  input  logic [N-1:0]    ALUres,
  input  logic [N-1:0]    store_data,
  input  logic [N-1:0]    NPCin,
  input  logic [N-1:0]    IMMin,
  input  logic [RW-1:0]   rd_in,
  input  logic            reg_wr_in,
  output logic            PC_sel,
  output logic            stall_out,
  mem_stage_lsu_if.master dmem,
  output logic            wb_valid,
  output logic [N-1:0]    ALUout,
  output logic [N-1:0]    NPCout,
  output logic [N-1:0]    IMMout,
  output logic [N-1:0]    wb_load,
  output logic [RW-1:0]   wb_rd,
  output logic            wb_reg_wr,
  output logic            wb_is_load,
  output logic            wb_err
);
  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  state_e state_q, state_d;

  logic [1:0]    size;
  logic [OW-1:0] off;
  logic          is_mem, go, cond, misaligned, illegal, acc_err;
  logic          retire, req, stall;
  logic [NB-1:0] be_mask;
  logic [N-1:0]  ld_sh, ld_mask, ld_top, ld_ext;

  assign size   = funct3[1:0];
  assign off    = ALUres[OW-1:0];
  assign is_mem = mem_rd_en | mem_wr_en;
  assign go     = ex_valid & ~ex_flush;

  always_comb begin
    case (funct3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign PC_sel = go & (state_q == S_IDLE) & (jump_en | (branch_en & cond));

  // Doubleword and lwu only exist on the 64-bit datapath.
  assign misaligned = |(off & OW'((4'd1 << size) - 4'd1));
  assign illegal    = (N == 32) & ((size == 2'b11) | (mem_rd_en & (funct3 == 3'b110)));
  assign acc_err    = is_mem & (misaligned | illegal);

  always_comb begin
    case (size)
      2'b00:   be_mask = NB'(1);
      2'b01:   be_mask = NB'(3);
      2'b10:   be_mask = NB'(15);
      default: be_mask = '1;
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = mem_wr_en;
  assign dmem.dmem_addr  = ALUres & ~N'(NB - 1);
  assign dmem.dmem_be    = be_mask << off;
  assign dmem.dmem_wdata = store_data << {off, 3'b000};

  always_comb begin
    case (size)
      2'b00:   ld_mask = N'(32'hFF);
      2'b01:   ld_mask = N'(32'hFFFF);
      2'b10:   ld_mask = N'(32'hFFFF_FFFF);
      default: ld_mask = '1;
    endcase
  end

  // ld_top isolates the sign bit of the selected access size.
  assign ld_sh  = dmem.dmem_rdata >> {off, 3'b000};
  assign ld_top = ld_mask & ~(ld_mask >> 1);
  assign ld_ext = (ld_sh & ld_mask) | ((~funct3[2] & |(ld_sh & ld_top)) ? ~ld_mask : '0);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (!is_mem || acc_err) begin
            retire = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem.dmem_gnt) begin
              if (mem_wr_en) retire = 1'b1;
              else begin
                stall   = 1'b1;
                state_d = S_WAIT;
              end
            end else begin
              stall   = 1'b1;
              state_d = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem.dmem_gnt) begin
          if (mem_wr_en) begin
            retire  = 1'b1;
            stall   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = ~dmem.dmem_rvalid;
        if (dmem.dmem_rvalid) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_out = stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wb_valid   <= 1'b0;
      ALUout     <= '0;
      NPCout     <= '0;
      IMMout     <= '0;
      wb_load    <= '0;
      wb_rd      <= '0;
      wb_reg_wr  <= 1'b0;
      wb_is_load <= 1'b0;
      wb_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_valid <= retire;
      if (retire) begin
        ALUout     <= ALUres;
        NPCout     <= NPCin;
        IMMout     <= IMMin;
        wb_load    <= ld_ext;
        wb_rd      <= rd_in;
        wb_reg_wr  <= reg_wr_in & ~acc_err;
        wb_is_load <= mem_rd_en;
        wb_err     <= acc_err;
      end else begin
        wb_reg_wr  <= 1'b0;
      end
    end
  end
endmodule
